alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: four-cycle IDLE/READ/EXEC/WB controller driving an external ALU and register file.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to make illegal ops set a sticky err and park in TRAP until reset.
module alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic [31:0] srca,
  output logic [31:0] srcb,
  output logic [4:0]  alucontrol,
  input  logic [31:0] res,
  input  logic        flag,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        busy,
  output logic        err
);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_TRAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_srca;
  logic [31:0] r_srcb;
  logic [31:0] r_res;
  logic        r_flag;
  logic [31:0] r_pc;

  logic [4:0]  w_op;
  logic        w_imm_form;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic        w_illegal;
  logic        w_cmp;
  logic        w_branch;
  logic        w_wr_en;

  assign w_op       = r_instr[4:0];
  assign w_imm_form = r_instr[5];
  assign w_rd       = r_instr[10:6];
  assign w_rs       = r_instr[15:11];
  assign w_imm      = r_instr[31:16];
  assign w_sext     = {{16{w_imm[15]}}, w_imm};
  assign w_illegal  = (w_op > 5'h11);
  assign w_cmp      = (w_op >= 5'h09) && (w_op <= 5'h10);
  assign w_branch   = w_imm_form && w_cmp;
  assign w_wr_en    = !w_branch && !w_illegal && (w_rd != 5'd0);

  assign pc   = r_pc;
  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    alucontrol  = '0;
    srca        = '0;
    srcb        = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_raddr_a  = w_rs;
    rf_raddr_b  = w_rd;
    case (r_state)
      S_IDLE: begin
        instr_ready = rst_n;
        // Present the incoming word's addresses early so a synchronous-read file has data in READ.
        rf_raddr_a  = instr[15:11];
        rf_raddr_b  = instr[10:6];
        if (instr_valid) w_next = S_READ;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        alucontrol = w_op;
        srca       = r_srca;
        srcb       = r_srcb;
        w_next     = S_WB;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        if (w_illegal) w_next = S_TRAP;
`endif
      end
      S_WB: begin
        rf_we    = w_wr_en;
        rf_waddr = w_rd;
        rf_wdata = r_res;
        w_next   = S_IDLE;
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_srca  <= '0;
      r_srcb  <= '0;
      r_res   <= '0;
      r_flag  <= 1'b0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) r_instr <= instr;
        S_READ: begin
          r_srca <= (w_imm_form && !w_cmp) ? w_sext : rf_rdata_a;
          r_srcb <= (w_imm_form && (w_op == 5'h11)) ? {16'b0, w_imm} : rf_rdata_b;
        end
        S_EXEC: begin
          r_res  <= res;
          r_flag <= flag;
        end
        S_WB: r_pc <= (w_branch && r_flag) ? (r_pc + {w_sext[29:0], 2'b00}) : (r_pc + 32'd4);
        default: ;
      endcase
    end
  end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_err <= 1'b0;
    else if (r_state == S_EXEC && w_illegal) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: stimulus queues expected per-instruction results, a monitor checks them.
`timescale 1ns/1ps
module tb_alu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [31:0] srca, srcb;
  logic [4:0]  alucontrol;
  logic [31:0] res;
  logic        flag;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pc;
  logic        busy, err;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .res(res), .flag(flag),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Environment: external ALU (result = srcb op srca) and a synchronous-read register file.
  always_comb begin
    res  = '0;
    flag = 1'b0;
    case (alucontrol)
      5'h00: res = srca;
      5'h01: res = srcb + srca;
      5'h02: res = srcb - srca;
      5'h03: res = srcb & srca;
      5'h04: res = srcb | srca;
      5'h05: res = srcb ^ srca;
      5'h06: res = srcb << srca[4:0];
      5'h07: res = srcb >> srca[4:0];
      5'h08: res = $signed(srcb) >>> srca[4:0];
      5'h09: flag = (srcb == srca);
      5'h0A: flag = (srcb != srca);
      5'h0B: flag = (srcb < srca);
      5'h0C: flag = (srcb > srca);
      5'h0D: flag = (srcb >= srca);
      5'h0E: flag = ($signed(srcb) < $signed(srca));
      5'h0F: flag = ($signed(srcb) > $signed(srca));
      5'h10: flag = ($signed(srcb) >= $signed(srca));
      5'h11: res = srcb << 16;
      default: ;
    endcase
    if (alucontrol >= 5'h09 && alucontrol <= 5'h10) res = {31'b0, flag};
  end

  logic [31:0] rf [32];
  logic        bd_we;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (bd_we) rf[bd_addr] <= bd_data;
    rf_rdata_a <= rf[rf_raddr_a];
    rf_rdata_b <= rf[rf_raddr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  op;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        trap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [15:0] imm);
    return {imm, rs, rd, i, op};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [31:0] npc, input logic trap);
    exp_t e;
    e.srca = a; e.srcb = b; e.op = op; e.we = we; e.waddr = wa; e.wdata = wd; e.pc = npc; e.trap = trap;
    return e;
  endfunction

  // Monitor: phase 1..3 = READ/EXEC/WB of the instruction handshaken in the previous IDLE, 4 = following cycle.
  exp_t cur;
  int   ph = 0;
  int   nxt_ph = 0;
  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        nxt_ph = 0;
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_ready", 32'(instr_ready), 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_op", 32'(alucontrol), 0);
        chk("rst_srca", srca, 0);
        chk("rst_srcb", srcb, 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
      end else begin
        ph = nxt_ph;
        if (ph == 1) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 1);
            cur = '0;
          end else cur = sb.pop_front();
        end
        if (ph == 2) begin
          chk("exec_op", 32'(alucontrol), 32'(cur.op));
          chk("exec_srca", srca, cur.srca);
          chk("exec_srcb", srcb, cur.srcb);
        end else begin
          chk("quiet_op", 32'(alucontrol), 0);
          chk("quiet_srca", srca, 0);
          chk("quiet_srcb", srcb, 0);
        end
        if (ph == 3) begin
          chk("wb_we", 32'(rf_we), 32'(cur.we));
          if (cur.we) begin
            chk("wb_waddr", 32'(rf_waddr), 32'(cur.waddr));
            chk("wb_wdata", rf_wdata, cur.wdata);
          end
        end else chk("stray_we", 32'(rf_we), 0);
        if (ph >= 1 && ph <= 3) begin
          chk("busy_mid", 32'(busy), 1);
          chk("ready_mid", 32'(instr_ready), 0);
        end
        if (ph == 4) begin
          chk("pc", pc, cur.pc);
          chk("post_busy", 32'(busy), 32'(cur.trap));
          chk("post_ready", 32'(instr_ready), 32'(!cur.trap));
          chk("post_err", 32'(err), 32'(cur.trap));
        end
        nxt_ph = (ph >= 1 && ph <= 3) ? ph + 1 : 0;
        if (instr_valid && instr_ready) nxt_ph = 1;
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic send(input logic [31:0] w, input exp_t e, input bit keep);
    int unsigned n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) chk("hs_timeout", 32'(instr_ready), 1);
    else begin
      sb.push_back(e);
      hs_cyc = cyc;
    end
    @(posedge clk); #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  int c1;
  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    poke(5'd0, 32'd0);  poke(5'd3, 32'd5);  poke(5'd4, 32'd7);  poke(5'd2, 32'd10);
    poke(5'd5, 32'd9);  poke(5'd6, 32'd9);  poke(5'd7, 32'h8000_0000); poke(5'd8, 32'd4);
    poke(5'd9, 32'hFFFF_FFFF); poke(5'd10, 32'd1); poke(5'd11, 32'h7FFF_FFFF);

    send(enc(5'h01, 1'b0, 5'd3, 5'd4, 16'h0000), mk(32'd7, 32'd5, 5'h01, 1'b1, 5'd3, 32'd12, 32'h4, 1'b0), 1'b0);
    send(enc(5'h02, 1'b1, 5'd2, 5'd0, 16'hFFFF), mk(32'hFFFF_FFFF, 32'd10, 5'h02, 1'b1, 5'd2, 32'd11, 32'h8, 1'b0), 1'b0);
    send(enc(5'h11, 1'b1, 5'd1, 5'd0, 16'h1234), mk(32'h1234, 32'h1234, 5'h11, 1'b1, 5'd1, 32'h1234_0000, 32'hC, 1'b0), 1'b0);
    send(enc(5'h09, 1'b1, 5'd6, 5'd5, 16'h003D), mk(32'd9, 32'd9, 5'h09, 1'b0, 5'd6, 32'd0, 32'h100, 1'b0), 1'b0);
    send(enc(5'h09, 1'b1, 5'd6, 5'd5, 16'hFFFE), mk(32'd9, 32'd9, 5'h09, 1'b0, 5'd6, 32'd0, 32'hF8, 1'b0), 1'b0);
    wait_idle();
    poke(5'd6, 32'd8);
    send(enc(5'h09, 1'b1, 5'd6, 5'd5, 16'hFFFE), mk(32'd9, 32'd8, 5'h09, 1'b0, 5'd6, 32'd0, 32'hFC, 1'b0), 1'b0);
    send(enc(5'h05, 1'b0, 5'd0, 5'd3, 16'h0000), mk(32'd12, 32'd0, 5'h05, 1'b0, 5'd0, 32'd0, 32'h100, 1'b0), 1'b0);
    send(enc(5'h08, 1'b0, 5'd7, 5'd8, 16'h0000), mk(32'd4, 32'h8000_0000, 5'h08, 1'b1, 5'd7, 32'hF800_0000, 32'h104, 1'b0), 1'b0);
    send(enc(5'h0E, 1'b0, 5'd9, 5'd10, 16'h0000), mk(32'd1, 32'hFFFF_FFFF, 5'h0E, 1'b1, 5'd9, 32'd1, 32'h108, 1'b0), 1'b0);

    // instr_valid held high across three back-to-back instructions
    send(enc(5'h01, 1'b1, 5'd11, 5'd0, 16'h0001), mk(32'd1, 32'h7FFF_FFFF, 5'h01, 1'b1, 5'd11, 32'h8000_0000, 32'h10C, 1'b0), 1'b1);
    c1 = hs_cyc;
    send(enc(5'h01, 1'b1, 5'd11, 5'd0, 16'h0001), mk(32'd1, 32'h8000_0000, 5'h01, 1'b1, 5'd11, 32'h8000_0001, 32'h110, 1'b0), 1'b1);
    chk("hs_gap1", 32'(hs_cyc - c1), 4);
    c1 = hs_cyc;
    send(enc(5'h01, 1'b1, 5'd11, 5'd0, 16'h0001), mk(32'd1, 32'h8000_0001, 5'h01, 1'b1, 5'd11, 32'h8000_0002, 32'h114, 1'b0), 1'b0);
    chk("hs_gap2", 32'(hs_cyc - c1), 4);

    // reset asserted during EXEC of an ADD
    wait_idle();
    send(enc(5'h01, 1'b0, 5'd3, 5'd4, 16'h0000), mk(32'd7, 32'd12, 5'h01, 1'b1, 5'd3, 32'd19, 32'h118, 1'b0), 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk("rel_ready", 32'(instr_ready), 1);
    chk("rel_pc", pc, 0);
    chk("rel_busy", 32'(busy), 0);
    chk("rel_nowrite", rf[3], 32'd12);
    @(posedge clk); #1;

    poke(5'd12, 32'h0000_FFFF);
    poke(5'd13, 32'd0);
    send(enc(5'h03, 1'b1, 5'd12, 5'd0, 16'h00F0), mk(32'hF0, 32'hFFFF, 5'h03, 1'b1, 5'd12, 32'hF0, 32'h4, 1'b0), 1'b0);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    send(enc(5'h15, 1'b0, 5'd13, 5'd0, 16'h0000), mk(32'd0, 32'd0, 5'h15, 1'b0, 5'd13, 32'd0, 32'h4, 1'b1), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    instr = enc(5'h01, 1'b0, 5'd3, 5'd4, 16'h0000);
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("trap_ready", 32'(instr_ready), 0);
      chk("trap_busy", 32'(busy), 1);
      chk("trap_err", 32'(err), 1);
      chk("trap_pc", pc, 32'h4);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk("trap_clr_err", 32'(err), 0);
    chk("trap_clr_ready", 32'(instr_ready), 1);
    @(posedge clk); #1;
`else
    send(enc(5'h15, 1'b0, 5'd13, 5'd0, 16'h0000), mk(32'd0, 32'd0, 5'h15, 1'b0, 5'd13, 32'd0, 32'h8, 1'b0), 1'b0);
    wait_idle();
    chk("nop_err", 32'(err), 0);
    chk("nop_nowrite", rf[13], 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
